// File: rtl/key_expansion_if.sv
// Handshake and data bundle between the AES flow controller (master) and the
// key schedule engine (slave).
interface key_expansion_if #(
    parameter int unsigned KEY_WIDTH  = 128,
    parameter int unsigned WORD_WIDTH = 32
);
    logic [KEY_WIDTH-1:0]  seed_key;
    logic                  seed_key_vld;
    logic                  rnd_key_gen;
    logic                  key_available;
    logic [KEY_WIDTH-1:0]  rnd_key_zero;
    logic [WORD_WIDTH-1:0] rnd_key_word;
    logic                  rnd_key_word_vld;
    logic [5:0]            rnd_key_idx;
    logic                  rnd_key_last;

    modport master (
        output seed_key, seed_key_vld, rnd_key_gen,
        input  key_available, rnd_key_zero, rnd_key_word, rnd_key_word_vld,
               rnd_key_idx, rnd_key_last
    );

    modport slave (
        input  seed_key, seed_key_vld, rnd_key_gen,
        output key_available, rnd_key_zero, rnd_key_word, rnd_key_word_vld,
               rnd_key_idx, rnd_key_last
    );
endinterface

// File: rtl/key_expansion.sv
// AES-128 key schedule: loads a seed key and emits w4..w43 one word per
// rnd_key_gen cycle, rewinding to w4 after w43 so the schedule can be reused.

// Combinational AES S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // x^254 = x^2 * x^4 * ... * x^128 gives the inverse (0 maps to 0).
    always_comb begin
        sq  = in_byte;
        inv = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module key_expansion #(
    parameter int unsigned KEY_WIDTH  = 128,
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned LAST_WORD  = 43
) (
    input  logic            clk,
    input  logic            reset,
    key_expansion_if.slave  kx
);
    localparam int unsigned NWORDS = KEY_WIDTH / WORD_WIDTH;
    localparam int unsigned NBYTES = WORD_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, READY, GEN} state_t;

    state_t                state_q, state_d;
    logic [KEY_WIDTH-1:0]  seed_q, seed_d;
    logic [WORD_WIDTH-1:0] win_q [NWORDS];
    logic [WORD_WIDTH-1:0] win_d [NWORDS];
    logic [5:0]            idx_q, idx_d;
    logic [7:0]            rcon_q, rcon_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  vld_q, vld_d;
    logic [5:0]            oidx_q, oidx_d;
    logic                  last_q, last_d;
    logic                  avail_q, avail_d;

    logic [WORD_WIDTH-1:0] rot_w, sub_w, new_w;

    assign rot_w = {win_q[NWORDS-1][WORD_WIDTH-9:0], win_q[NWORDS-1][WORD_WIDTH-1:WORD_WIDTH-8]};

    for (genvar b = 0; b < NBYTES; b++) begin : g_sub
        aes_sbox u_sbox (
            .in_byte  (rot_w[8*b +: 8]),
            .out_byte (sub_w[8*b +: 8])
        );
    end

    always_comb begin
        if (idx_q[1:0] == 2'b00)
            new_w = win_q[0] ^ sub_w ^ {rcon_q, {(WORD_WIDTH-8){1'b0}}};
        else
            new_w = win_q[0] ^ win_q[NWORDS-1];
    end

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        win_d   = win_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        word_d  = word_q;
        vld_d   = 1'b0;
        oidx_d  = oidx_q;
        last_d  = 1'b0;

        if (kx.seed_key_vld) begin
            state_d = READY;
            seed_d  = kx.seed_key;
            for (int unsigned k = 0; k < NWORDS; k++)
                win_d[k] = kx.seed_key[KEY_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH];
            idx_d   = 6'd4;
            rcon_d  = 8'h01;
        end else if (kx.rnd_key_gen && state_q != IDLE) begin
            word_d = new_w;
            vld_d  = 1'b1;
            oidx_d = idx_q;
            if (idx_q == 6'(LAST_WORD)) begin
                // Rewind to the seed so the next block reuses the schedule.
                last_d  = 1'b1;
                state_d = READY;
                for (int unsigned k = 0; k < NWORDS; k++)
                    win_d[k] = seed_q[KEY_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH];
                idx_d   = 6'd4;
                rcon_d  = 8'h01;
            end else begin
                state_d = GEN;
                for (int unsigned k = 0; k < NWORDS-1; k++)
                    win_d[k] = win_q[k+1];
                win_d[NWORDS-1] = new_w;
                idx_d = idx_q + 6'd1;
                if (idx_q[1:0] == 2'b00)
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
        end

        avail_d = (state_d == READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            seed_q  <= '0;
            win_q   <= '{default: '0};
            idx_q   <= 6'd4;
            rcon_q  <= 8'h01;
            word_q  <= '0;
            vld_q   <= 1'b0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
            avail_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            win_q   <= win_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            word_q  <= word_d;
            vld_q   <= vld_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
            avail_q <= avail_d;
        end
    end

    assign kx.key_available    = avail_q;
    assign kx.rnd_key_zero     = seed_q;
    assign kx.rnd_key_word     = word_q;
    assign kx.rnd_key_word_vld = vld_q;
    assign kx.rnd_key_idx      = oidx_q;
    assign kx.rnd_key_last     = last_q;
endmodule
